uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation serial receive front end of the PID controller's UART path. It deserialises an asynchronous serial line with configurable data width, oversampling ratio, parity and stop bits. Each bit is resolved by 3-sample majority voting. Every frame is reported with parity, framing and overrun status through a valid/ready handshake to the command parser.

---
 rtl/uart_rx_param.sv | 149 ++++++++++++++
 tb/tb_uart_rx_param.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote per bit,
// parity/framing/overrun status delivered through a valid/ready handshake.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] TickLo   = CW'(M - 1);
  localparam logic [CW-1:0] TickMid  = CW'(M);
  localparam logic [CW-1:0] TickVote = CW'(M + 1);
  localparam logic [CW-1:0] TickLast = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LastStop = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHigh
  } state_e;

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   rx_meta, rxs;
  logic                   samp_lo, samp_mid;
  logic                   perr_acc, ferr_acc;
  logic                   vote, ones_odd, par_bad, frame_bad, at_wrap, done;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rxs     <= rx_meta;
    end
  end

  // Third sample is the live line at tick M+1.
  assign vote      = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);
  assign ones_odd  = ^{shift, vote};
  assign par_bad   = (PARITY == 1) ? ~ones_odd : ones_odd;
  assign frame_bad = ferr_acc | ~vote;
  assign at_wrap   = (cnt == TickLast);
  assign done      = clk_en && (state == StStop) && (cnt == TickVote) && (bit_idx == LastStop);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      samp_lo    <= 1'b1;
      samp_mid   <= 1'b1;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done) begin
        data       <= shift;
        data_valid <= 1'b1;
        parity_err <= perr_acc;
        frame_err  <= frame_bad;
        overrun    <= data_valid && !data_ready;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      if (clk_en) begin
        if (cnt == TickLo)  samp_lo  <= rxs;
        if (cnt == TickMid) samp_mid <= rxs;
        cnt <= at_wrap ? '0 : cnt + CW'(1);
        unique case (state)
          StIdle: begin
            cnt <= '0;
            if (!rxs) begin
              state    <= StStart;
              cnt      <= CW'(1);
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
          StStart: begin
            if (cnt == TickVote && vote) begin
              state <= StIdle;
              cnt   <= '0;
            end else if (at_wrap) begin
              state   <= StData;
              bit_idx <= '0;
            end
          end
          StData: begin
            if (cnt == TickVote) shift <= {vote, shift[DATA_BITS-1:1]};
            if (at_wrap) begin
              if (bit_idx == LastData) begin
                bit_idx <= '0;
                state   <= (PARITY != 0) ? StParity : StStop;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end
          StParity: begin
            if (cnt == TickVote) perr_acc <= par_bad;
            if (at_wrap) state <= StStop;
          end
          StStop: begin
            if (cnt == TickVote) begin
              if (!vote) ferr_acc <= 1'b1;
              // Finish mid-bit so back-to-back frames keep their start edge.
              if (bit_idx == LastStop) begin
                state <= frame_bad ? StWaitHigh : StIdle;
                cnt   <= '0;
              end
            end else if (at_wrap) begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          StWaitHigh: begin
            cnt <= '0;
            if (rxs) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven from per-tick level queues and
// checked against a tick-indexed frame model, plus directed literal checks.
module tb_uart_rx_param;

  localparam int NCFG  = 3;
  localparam int HSZ   = 32768;
  localparam int BOUND = 150000;
  localparam int C_DB  [NCFG] = '{8, 8, 7};
  localparam int C_OS  [NCFG] = '{16, 16, 8};
  localparam int C_PAR [NCFG] = '{0, 2, 0};
  localparam int C_SB  [NCFG] = '{1, 1, 2};

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       clk_en = 1'b0;
  logic [2:0] rx_line    = 3'b111;
  logic [2:0] data_ready = 3'b000;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [2:0] valid_v, perr_v, ferr_v, ovr_v;
  logic [8:0] dut_data [NCFG];

  always #5 clk_in = ~clk_in;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk_in(clk_in), .reset(reset), .clk_en(clk_en), .rx_data(rx_line[0]), .data(data_a),
    .data_valid(valid_v[0]), .data_ready(data_ready[0]), .parity_err(perr_v[0]),
    .frame_err(ferr_v[0]), .overrun(ovr_v[0]));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_dut_b (
    .clk_in(clk_in), .reset(reset), .clk_en(clk_en), .rx_data(rx_line[1]), .data(data_b),
    .data_valid(valid_v[1]), .data_ready(data_ready[1]), .parity_err(perr_v[1]),
    .frame_err(ferr_v[1]), .overrun(ovr_v[1]));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) u_dut_c (
    .clk_in(clk_in), .reset(reset), .clk_en(clk_en), .rx_data(rx_line[2]), .data(data_c),
    .data_valid(valid_v[2]), .data_ready(data_ready[2]), .parity_err(perr_v[2]),
    .frame_err(ferr_v[2]), .overrun(ovr_v[2]));

  assign dut_data[0] = {1'b0, data_a};
  assign dut_data[1] = {1'b0, data_b};
  assign dut_data[2] = {2'b00, data_c};

  logic q0[$], q1[$], q2[$];
  int   rdy_mode [NCFG];  // 0 random, 1 low, 2 high, 3 high only on predicted completion
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: synchronised line history indexed by tick number.
  bit         hist [NCFG][HSZ];
  int         tick_n = 0;
  int         m_mode [NCFG];  // 0 hunting for start, 1 in frame, 2 waiting for high
  int         m_t0   [NCFG];
  int         m_off  [NCFG];
  logic       m_s1 [NCFG], m_s2 [NCFG];
  logic [8:0] e_data [NCFG];
  logic       e_valid [NCFG], e_pe [NCFG], e_fe [NCFG], e_ov [NCFG];

  function automatic int frame_len(int g);
    int k = C_DB[g] + ((C_PAR[g] != 0) ? 1 : 0) + C_SB[g];
    return k * C_OS[g] + C_OS[g] / 2 + 1;
  endfunction

  function automatic bit vote_at(int g, int t);
    int m = C_OS[g] / 2;
    int n = int'(hist[g][(t + m - 1) % HSZ]) + int'(hist[g][(t + m) % HSZ])
          + int'(hist[g][(t + m + 1) % HSZ]);
    return n >= 2;
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic push_level(input int g, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      case (g)
        0:       q0.push_back(lvl);
        1:       q1.push_back(lvl);
        default: q2.push_back(lvl);
      endcase
    end
  endtask

  task automatic push_frame(input int g, input int unsigned d, input logic pbit,
                            input logic stop_lvl, input int gap);
    push_level(g, 1'b0, C_OS[g]);
    for (int i = 0; i < C_DB[g]; i++) push_level(g, logic'((d >> i) & 1), C_OS[g]);
    if (C_PAR[g] != 0) push_level(g, pbit, C_OS[g]);
    for (int j = 0; j < C_SB[g]; j++) push_level(g, stop_lvl, C_OS[g]);
    push_level(g, 1'b1, gap);
  endtask

  task automatic drain();
    int i = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && i < BOUND) begin
      @(negedge clk_in);
      i++;
    end
    check("drain_within_bound", (i < BOUND) ? 1 : 0, 1);
    repeat (60) @(negedge clk_in);
  endtask

  task automatic set_mode(input int g, input int mode);
    @(posedge clk_in);
    #1 rdy_mode[g] = mode;
  endtask

  task automatic accept(input int g);
    set_mode(g, 2);
    set_mode(g, 1);
    @(negedge clk_in);
  endtask

  // Driver: one tick every 3..5 cycles so each queued level is seen by exactly one tick.
  initial begin
    int gap = 0;
    forever begin
      @(negedge clk_in);
      if (clk_en) begin
        rx_line[0] = (q0.size() != 0) ? q0.pop_front() : 1'b1;
        rx_line[1] = (q1.size() != 0) ? q1.pop_front() : 1'b1;
        rx_line[2] = (q2.size() != 0) ? q2.pop_front() : 1'b1;
      end
      if (gap == 0) begin
        clk_en = 1'b1;
        gap    = $urandom_range(2, 4);
      end else begin
        clk_en = 1'b0;
        gap--;
      end
      for (int g = 0; g < NCFG; g++) begin
        case (rdy_mode[g])
          0:       data_ready[g] = ($urandom_range(0, 3) == 0);
          1:       data_ready[g] = 1'b0;
          2:       data_ready[g] = 1'b1;
          default: data_ready[g] = clk_en && (m_mode[g] == 1) &&
                                   (tick_n == m_t0[g] + frame_len(g));
        endcase
      end
    end
  end

  // Model
  initial begin
    logic       s;
    bit         done;
    logic [8:0] d;
    int         ones, idx;
    logic       pe, fe, p;
    forever begin
      @(posedge clk_in or posedge reset);
      if (reset) begin
        for (int g = 0; g < NCFG; g++) begin
          m_s1[g] = 1'b1; m_s2[g] = 1'b1; m_mode[g] = 0;
          e_valid[g] = 1'b0; e_ov[g] = 1'b0; e_fe[g] = 1'b0; e_pe[g] = 1'b0; e_data[g] = '0;
        end
      end else begin
        for (int g = 0; g < NCFG; g++) begin
          s = m_s2[g];
          m_s2[g] = m_s1[g];
          m_s1[g] = rx_line[g];
          done = 1'b0;
          if (clk_en) begin
            hist[g][tick_n % HSZ] = s;
            if (m_mode[g] == 0) begin
              if (!s) begin
                m_t0[g]   = tick_n;
                m_mode[g] = 1;
              end
            end else if (m_mode[g] == 1) begin
              if (tick_n == m_t0[g] + C_OS[g] / 2 + 1 && vote_at(g, m_t0[g])) begin
                m_mode[g] = 0;
              end else if (tick_n == m_t0[g] + frame_len(g)) begin
                d = '0; ones = 0;
                for (int i = 0; i < C_DB[g]; i++) begin
                  d[i] = vote_at(g, m_t0[g] + (1 + i) * C_OS[g]);
                  ones += int'(d[i]);
                end
                idx = 1 + C_DB[g];
                pe  = 1'b0;
                if (C_PAR[g] != 0) begin
                  p  = vote_at(g, m_t0[g] + idx * C_OS[g]);
                  pe = (C_PAR[g] == 1) ? ((ones + int'(p)) % 2 == 0)
                                       : ((ones + int'(p)) % 2 == 1);
                  idx++;
                end
                fe = 1'b0;
                for (int j = 0; j < C_SB[g]; j++)
                  if (!vote_at(g, m_t0[g] + (idx + j) * C_OS[g])) fe = 1'b1;
                m_off[g]  = tick_n - m_t0[g];
                m_mode[g] = fe ? 2 : 0;
                done      = 1'b1;
              end
            end else if (s) begin
              m_mode[g] = 0;
            end
          end
          if (done) begin
            e_ov[g]    = e_valid[g] && !data_ready[g];
            e_valid[g] = 1'b1;
            e_data[g]  = d;
            e_pe[g]    = pe;
            e_fe[g]    = fe;
          end else if (e_valid[g] && data_ready[g]) begin
            e_valid[g] = 1'b0;
            e_ov[g]    = 1'b0;
          end
        end
        if (clk_en) tick_n++;
      end
    end
  end

  // Compare DUT against model whenever either side changes.
  initial begin
    logic [12:0] dv, ev;
    logic [12:0] pdv [NCFG];
    logic [12:0] pev [NCFG];
    for (int g = 0; g < NCFG; g++) begin
      pdv[g] = '1;
      pev[g] = '1;
    end
    forever begin
      @(negedge clk_in);
      for (int g = 0; g < NCFG; g++) begin
        dv = {valid_v[g], ovr_v[g], ferr_v[g], perr_v[g], dut_data[g]};
        ev = {e_valid[g], e_ov[g], e_fe[g], e_pe[g], e_data[g]};
        if (dv != pdv[g] || ev != pev[g]) check($sformatf("model_cfg%0d", g), dv, ev);
        pdv[g] = dv;
        pev[g] = ev;
      end
    end
  end

  function automatic logic [3:0] flags(int g);
    return {valid_v[g], perr_v[g], ferr_v[g], ovr_v[g]};
  endfunction

  initial begin
    logic [8:0] rd;
    logic       pb;
    for (int g = 0; g < NCFG; g++) rdy_mode[g] = 1;
    #2 reset = 1'b1;
    repeat (4) @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("reset_flags_cfg%0d", g), flags(g), 0);
      check($sformatf("reset_data_cfg%0d", g), dut_data[g], 0);
    end

    // 8N1 basic frame and handshake
    push_frame(0, 'hA5, 1'b0, 1'b1, 20);
    drain();
    check("a5_data", dut_data[0], 'hA5);
    check("a5_flags", flags(0), 4'b1000);
    check("a5_model_data", e_data[0], 'hA5);
    check("a5_model_offset", m_off[0], 153);
    accept(0);
    check("a5_accept_valid", valid_v[0], 0);
    check("a5_accept_data_kept", dut_data[0], 'hA5);

    // Short low pulse is rejected
    push_level(0, 1'b0, 4);
    push_level(0, 1'b1, 40);
    drain();
    check("glitch_valid", valid_v[0], 0);

    // Break: one word with framing error, then silence until the line returns high
    push_level(0, 1'b0, 3 * 160);
    push_level(0, 1'b1, 30);
    drain();
    check("break_data", dut_data[0], 'h00);
    check("break_flags", flags(0), 4'b1010);
    accept(0);
    push_frame(0, 'h5A, 1'b0, 1'b1, 20);
    drain();
    check("after_break_data", dut_data[0], 'h5A);
    check("after_break_flags", flags(0), 4'b1000);
    accept(0);

    // Overrun on back-to-back frames
    push_frame(0, 'h11, 1'b0, 1'b1, 0);
    push_frame(0, 'h22, 1'b0, 1'b1, 20);
    drain();
    check("overrun_data", dut_data[0], 'h22);
    check("overrun_flags", flags(0), 4'b1001);
    accept(0);
    check("overrun_cleared", {valid_v[0], ovr_v[0]}, 0);

    // Completion and accept on the same edge
    push_frame(0, 'h44, 1'b0, 1'b1, 20);
    drain();
    set_mode(0, 3);
    push_frame(0, 'h55, 1'b0, 1'b1, 20);
    drain();
    set_mode(0, 1);
    @(negedge clk_in);
    check("same_edge_data", dut_data[0], 'h55);
    check("same_edge_flags", flags(0), 4'b1000);
    accept(0);

    // Even parity
    push_frame(1, 'h03, 1'b1, 1'b1, 20);
    drain();
    check("even_par_bad_data", dut_data[1], 'h03);
    check("even_par_bad_flags", flags(1), 4'b1100);
    accept(1);
    push_frame(1, 'h03, 1'b0, 1'b1, 20);
    drain();
    check("even_par_ok_flags", flags(1), 4'b1000);
    accept(1);

    // Randomised traffic on all three configurations
    for (int g = 0; g < NCFG; g++) set_mode(g, 0);
    for (int n = 0; n < 10; n++) begin
      for (int g = 0; g < NCFG; g++) begin
        if ($urandom_range(0, 5) == 0) begin
          push_level(g, 1'b0, $urandom_range(1, 3));
          push_level(g, 1'b1, $urandom_range(3, 10));
        end
        rd = 9'($urandom_range(0, (1 << C_DB[g]) - 1));
        pb = ^rd;
        if ($urandom_range(0, 3) == 0) pb = ~pb;
        push_frame(g, rd, pb, ($urandom_range(0, 7) != 0), $urandom_range(0, 12));
      end
    end
    for (int g = 0; g < NCFG; g++) push_level(g, 1'b1, 40);
    drain();
    for (int g = 0; g < NCFG; g++) set_mode(g, 2);
    repeat (4) @(negedge clk_in);
    for (int g = 0; g < NCFG; g++) set_mode(g, 1);
    @(negedge clk_in);

    // 7-bit, 2 stop bits, OVERSAMPLE 8, then reset mid-frame
    push_frame(2, 'h7F, 1'b0, 1'b1, 20);
    drain();
    check("c7f_data", dut_data[2], 'h7F);
    check("c7f_flags", flags(2), 4'b1000);
    check("c7f_model_offset", m_off[2], 77);
    push_frame(2, 'h2A, 1'b0, 1'b1, 20);
    for (int i = 0; i < BOUND && q2.size() > 60; i++) @(negedge clk_in);
    @(posedge clk_in);
    #1 reset = 1'b1;
    q2.delete();
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("midreset_flags_cfg%0d", g), flags(g), 0);
      check($sformatf("midreset_data_cfg%0d", g), dut_data[g], 0);
    end
    push_level(2, 1'b1, 100);
    drain();
    check("partial_discarded_valid", valid_v[2], 0);
    check("partial_discarded_data", dut_data[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
